reg_write_tracker: RTL and testbench

REG_WRITE_TRACKER -- requirements
Module: reg_write_tracker

---
 rtl/otter_pkg.sv | 31 +++
 rtl/reg_write_tracker_if.sv | 27 ++
 rtl/instr_reg_use.sv | 47 ++++
 rtl/reg_write_tracker.sv | 91 +++++++++
 tb/tb_reg_write_tracker.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/otter_pkg.sv
// Shared types for the register-write tracker.
//   opcode_t   : RV32I major opcodes (instruction bits [6:0])
//   slot_t     : one pipeline-stage scoreboard entry {valid, rd}
//   slot_hit() : true when a valid slot targets the given register
package otter_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0};

  function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
    return s.valid && (s.rd == r);
  endfunction

endpackage

// File: rtl/reg_write_tracker_if.sv
// Issue/query bundle between decode and the register-write tracker.
//   issue_valid/issue_ir : instruction leaving decode this edge
//   advance/flush        : pipeline enable and youngest-writer squash
//   dec_ir               : instruction currently in decode (query)
//   rs1_busy/rs2_busy    : query results; stall = either busy
//   inflight             : number of valid scoreboard slots
interface reg_write_tracker_if;
  logic        issue_valid;
  logic [31:0] issue_ir;
  logic        advance;
  logic        flush;
  logic [31:0] dec_ir;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        stall;
  logic [1:0]  inflight;

  modport master (
    output issue_valid, issue_ir, advance, flush, dec_ir,
    input  rs1_busy, rs2_busy, stall, inflight
  );

  modport slave (
    input  issue_valid, issue_ir, advance, flush, dec_ir,
    output rs1_busy, rs2_busy, stall, inflight
  );
endinterface

// File: rtl/instr_reg_use.sv
// Combinational register-usage decode of one RV32I instruction word.
//   ir        : instruction word
//   writes_rd : writes a non-zero rd (not BRANCH/STORE, rd != x0)
//   uses_rs1  : reads rs1 (all but LUI/AUIPC/JAL)
//   uses_rs2  : reads rs2 (BRANCH, STORE, OP only)
//   rd/rs1/rs2: register fields
// Unknown opcodes are treated as writing rd and reading rs1 only.
module instr_reg_use
  import otter_pkg::*;
(
  input  logic [31:0] ir,
  output logic        writes_rd,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic [6:0] opc;
  logic       has_rd;
  logic       unused_fields;

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign unused_fields = ^{ir[31:25], ir[14:12]};

  always_comb begin
    has_rd   = 1'b1;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opc)
      LUI, AUIPC, JAL: uses_rs1 = 1'b0;
      BRANCH, STORE: begin
        has_rd   = 1'b0;
        uses_rs2 = 1'b1;
      end
      OP:      uses_rs2 = 1'b1;
      default: ;
    endcase
  end

  assign writes_rd = has_rd && (rd != 5'd0);

endmodule

// File: rtl/reg_write_tracker.sv
// Scoreboard of in-flight register writes across EX/MEM/WB. Issued writers
// enter EX and shift toward WB on advance; WB stays busy until one more
// advance (no regfile bypass). Decode queries are answered combinationally
// from the registered slots.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : reg_write_tracker_if.slave (issue, control, query, status)
module reg_write_tracker
  import otter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  reg_write_tracker_if.slave   bus
);

  slot_t ex_q,  ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q,  wb_d;

  logic       iss_writes_rd;
  logic [4:0] iss_rd;
  logic       iss_unused_rs1_use, iss_unused_rs2_use;
  logic [4:0] iss_unused_rs1, iss_unused_rs2;

  logic       dec_uses_rs1, dec_uses_rs2;
  logic [4:0] dec_rs1, dec_rs2;
  logic       dec_unused_writes;
  logic [4:0] dec_unused_rd;

  instr_reg_use u_issue_use (
    .ir        (bus.issue_ir),
    .writes_rd (iss_writes_rd),
    .uses_rs1  (iss_unused_rs1_use),
    .uses_rs2  (iss_unused_rs2_use),
    .rd        (iss_rd),
    .rs1       (iss_unused_rs1),
    .rs2       (iss_unused_rs2)
  );

  instr_reg_use u_dec_use (
    .ir        (bus.dec_ir),
    .writes_rd (dec_unused_writes),
    .uses_rs1  (dec_uses_rs1),
    .uses_rs2  (dec_uses_rs2),
    .rd        (dec_unused_rd),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2)
  );

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (bus.advance) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = SLOT_EMPTY;
      if (!bus.flush && bus.issue_valid && iss_writes_rd) begin
        ex_d = '{valid: 1'b1, rd: iss_rd};
      end
    end else if (bus.flush) begin
      ex_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= SLOT_EMPTY;
      mem_q <= SLOT_EMPTY;
      wb_q  <= SLOT_EMPTY;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  logic rs1_hit, rs2_hit;

  // Any matching slot keeps the register busy, so duplicate rd values clear
  // only once the last matching writer has drained.
  assign rs1_hit = slot_hit(ex_q, dec_rs1) || slot_hit(mem_q, dec_rs1) ||
                   slot_hit(wb_q, dec_rs1);
  assign rs2_hit = slot_hit(ex_q, dec_rs2) || slot_hit(mem_q, dec_rs2) ||
                   slot_hit(wb_q, dec_rs2);

  assign bus.rs1_busy = dec_uses_rs1 && (dec_rs1 != 5'd0) && rs1_hit;
  assign bus.rs2_busy = dec_uses_rs2 && (dec_rs2 != 5'd0) && rs2_hit;
  assign bus.stall    = bus.rs1_busy || bus.rs2_busy;
  assign bus.inflight = 2'(ex_q.valid) + 2'(mem_q.valid) + 2'(wb_q.valid);

endmodule

// File: tb/tb_reg_write_tracker.sv
module tb_reg_write_tracker;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned errors = 0;
  int unsigned checks = 0;

  reg_write_tracker_if bus ();

  reg_write_tracker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Set inputs mid-cycle, take one rising edge, settle 1 time unit after it.
  task automatic drive(input logic v, input logic [31:0] ir, input logic adv, input logic fl);
    bus.issue_valid = v;
    bus.issue_ir    = ir;
    bus.advance     = adv;
    bus.flush       = fl;
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic query(input logic [31:0] ir);
    bus.dec_ir = ir;
    #1;
  endtask

  task automatic status(input string tag, input logic st, input logic [1:0] inf);
    check({tag, ".stall"}, 32'(bus.stall), 32'(st));
    check({tag, ".inflight"}, 32'(bus.inflight), 32'(inf));
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  logic       exp_st [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] exp_in [4] = '{2'd1, 2'd1, 2'd1, 2'd0};

  initial begin
    rst_n = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_ir    = '0;
    bus.advance     = 1'b0;
    bus.flush       = 1'b0;
    bus.dec_ir      = 32'h00528333;
    #1;
    status("reset", 1'b0, 2'd0);
    check("reset.rs1_busy", 32'(bus.rs1_busy), 32'd0);
    check("reset.rs2_busy", 32'(bus.rs2_busy), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // addi x5 then add x6,x5,x5: busy through EX, MEM, WB
    query(32'h00528333);
    drive(1'b1, 32'h00500293, 1'b1, 1'b0);
    check("raw.rs1_busy", 32'(bus.rs1_busy), 32'd1);
    check("raw.rs2_busy", 32'(bus.rs2_busy), 32'd1);
    status("raw0", exp_st[0], exp_in[0]);
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      status($sformatf("raw%0d", i), exp_st[i], exp_in[i]);
    end

    // store / branch never write, even with a non-zero rd field
    drive(1'b1, 32'h00502223, 1'b1, 1'b0);   // sw x5,4(x0): rd field x4
    query(32'h00420333);                      // add x6,x4,x4
    status("store", 1'b0, 2'd0);
    drive(1'b1, 32'h00000463, 1'b1, 1'b0);   // beq x0,x0,8: rd field x8
    query(32'h008404B3);                      // add x9,x8,x8
    status("branch", 1'b0, 2'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // x0 writer ignored
    drive(1'b1, 32'h00000013, 1'b1, 1'b0);
    query(32'h00000033);
    status("x0", 1'b0, 2'd0);

    // flush with advance squashes incoming issue; older writer moves on
    drive(1'b1, 32'h00000513, 1'b1, 1'b0);   // addi x10
    status("pre_flush", 1'b0, 2'd1);
    drive(1'b1, 32'h00700393, 1'b1, 1'b1);   // addi x7 squashed
    query(32'h00738433);
    status("flush_adv", 1'b0, 2'd1);
    query(32'h000505B3);                      // add x11,x10,x0
    check("flush_adv.x10", 32'(bus.stall), 32'd1);
    // flush without advance clears only EX
    drive(1'b1, 32'h00600313, 1'b1, 1'b0);   // addi x6 -> EX, x10 -> WB
    check("two_in_flight", 32'(bus.inflight), 32'd2);
    drive(1'b1, 32'h00900493, 1'b0, 1'b1);   // issue ignored, EX squashed
    query(32'h006303B3);                      // add x7,x6,x6
    status("flush_hold", 1'b0, 2'd1);
    query(32'h000505B3);
    check("flush_hold.x10", 32'(bus.stall), 32'd1);
    drain();
    check("drained", 32'(bus.inflight), 32'd0);

    // hold for 10 cycles: stays busy, issue ignored
    drive(1'b1, 32'h00500293, 1'b1, 1'b0);
    query(32'h00528333);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h00600313, 1'b0, 1'b0);
      status($sformatf("hold%0d", i), 1'b1, 2'd1);
    end

    // operand-use decode with x5 still in EX
    query(32'h00028337);                      // lui x6: bits19:15 = 5
    check("lui", 32'(bus.stall), 32'd0);
    query(32'h00500313);                      // addi x6,x0,5: rs2 field 5
    check("opimm_rs2", 32'(bus.stall), 32'd0);
    query(32'h0050A023);                      // sw x5,0(x1)
    check("sw.rs1", 32'(bus.rs1_busy), 32'd0);
    check("sw.rs2", 32'(bus.rs2_busy), 32'd1);
    query(32'h00028313);                      // addi x6,x5,0
    check("addi.rs1", 32'(bus.rs1_busy), 32'd1);
    check("addi.rs2", 32'(bus.rs2_busy), 32'd0);
    query(32'h0052800B);                      // unknown opcode, rs1=rs2=x5
    check("unk_q.rs1", 32'(bus.rs1_busy), 32'd1);
    check("unk_q.rs2", 32'(bus.rs2_busy), 32'd0);
    drain();

    // unknown opcode issued writes rd
    drive(1'b1, 32'h0000028B, 1'b1, 1'b0);
    query(32'h00528333);
    status("unk_issue", 1'b1, 2'd1);
    drain();

    // three x5 writers, async reset between edges
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h00500293, 1'b1, 1'b0);
    status("dup3", 1'b1, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    status("async_rst", 1'b0, 2'd0);
    @(posedge clk); #1;
    status("rst_held", 1'b0, 2'd0);
    rst_n = 1'b1;
    drive(1'b1, 32'h00500293, 1'b1, 1'b0);
    status("post_rst", 1'b1, 2'd1);

    // duplicates clear only after the last one leaves
    drive(1'b1, 32'h00500293, 1'b1, 1'b0);
    drive(1'b1, 32'h00500293, 1'b1, 1'b0);
    status("dup_full", 1'b1, 2'd3);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    status("dup2", 1'b1, 2'd2);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    status("dup1", 1'b1, 2'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    status("dup0", 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
